// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-low, bits [6:0] = g..a.
package seg_pkg;

  localparam int NIB_W = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Uses the shared segment table from seg_pkg.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [6:0]       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame channel snapshot.
// Define SEG_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SEL_W-1:0]                 SW,
  input  logic [(2**SEL_W)*DIGITS*4-1:0]   data_in,
  input  logic [(2**SEL_W)*DIGITS-1:0]     dp_in,
  output logic [7:0]                       LED_display,
  output logic [DIGITS-1:0]                LED_pos,
  output logic                             frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SNP_W = DIGITS * NIB_W;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [SNP_W-1:0]  snap_data;
  logic [DIGITS-1:0] snap_dp;
  logic              tick;
  logic              wrap;
  logic [NIB_W-1:0]  cur_nib;
  logic [6:0]        cur_seg;
  logic [7:0]        disp_next;

  logic              upd0;
  logic              fs0;
  logic              upd1;
  logic              s1_fs;
  logic [DIGITS-1:0] s1_pos;
  logic [7:0]        s1_seg;

  assign tick    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign wrap    = (idx == IDX_W'(DIGITS - 1));
  assign cur_nib = snap_data[idx*NIB_W +: NIB_W];

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              run;

  // lz[k]: digit k and everything to its left is zero with no dp
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run   = run & (snap_data[k*NIB_W +: NIB_W] == '0)
                  & ~snap_dp[k];
      lz[k] = run;
    end
    lz[0] = 1'b0;
  end

  always_comb begin
    disp_next = {~snap_dp[idx], cur_seg};
    if (lz[idx]) disp_next = SEG_BLANK;
  end
`else
  always_comb begin
    disp_next = {~snap_dp[idx], cur_seg};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= IDX_W'(DIGITS - 1);
      snap_data   <= '0;
      snap_dp     <= '0;
      upd0        <= 1'b0;
      fs0         <= 1'b0;
      upd1        <= 1'b0;
      s1_fs       <= 1'b0;
      s1_pos      <= '1;
      s1_seg      <= SEG_BLANK;
      LED_pos     <= '1;
      LED_display <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
        if (wrap) begin
          snap_data <= data_in[SW*SNP_W +: SNP_W];
          snap_dp   <= dp_in[SW*DIGITS +: DIGITS];
        end
      end
      upd0 <= tick;
      fs0  <= tick & wrap;
      upd1 <= upd0;
      if (upd0) begin
        s1_pos <= ~(DIGITS'(1) << idx);
        s1_seg <= disp_next;
        s1_fs  <= fs0;
      end
      frame_start <= upd1 & s1_fs;
      if (upd1) begin
        LED_pos     <= s1_pos;
        LED_display <= s1_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a per-cycle timing model.
// Honours SEG_LZ_BLANK_EN the same way as the design.
module tb_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SEL_W    = 3;
  localparam int SCAN_DIV = 4;
  localparam int CH       = 2**SEL_W;
  localparam int LAT      = SCAN_DIV + 1;

  logic                     clk;
  logic                     rst;
  logic [SEL_W-1:0]         sw;
  logic [CH*DIGITS*4-1:0]   data;
  logic [CH*DIGITS-1:0]     dp;
  logic [7:0]               led_display;
  logic [DIGITS-1:0]        led_pos;
  logic                     fs;

  seg_scan_driver #(
    .DIGITS   (DIGITS),
    .SEL_W    (SEL_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .SW          (sw),
    .data_in     (data),
    .dp_in       (dp),
    .LED_display (led_display),
    .LED_pos     (led_pos),
    .frame_start (fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int cur_digit = -1;
  int cur_src = -1;

  logic [SEL_W-1:0]       hist_sw   [0:1023];
  logic [CH*DIGITS*4-1:0] hist_data [0:1023];
  logic [CH*DIGITS-1:0]   hist_dp   [0:1023];

  string letters [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic logic [6:0] hex_seg(int v);
    logic [6:0] r;
    string s;
    r = 7'h7F;
    s = letters[v];
    for (int i = 0; i < s.len(); i++) r[s[i] - "a"] = 1'b0;
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d: observed %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic step();
    logic [DIGITS-1:0] e_pos;
    logic [7:0]        e_disp;
    logic              e_fs;
    logic [CH*DIGITS*4-1:0] td;
    logic [CH*DIGITS-1:0]   tp;
    int j, d, s, ch;
    bit blank;
    @(posedge clk);
    if (!rst) begin
      hist_sw[n]   = sw;
      hist_data[n] = data;
      hist_dp[n]   = dp;
    end
    #1;
    e_pos = '1; e_disp = 8'hFF; e_fs = 1'b0;
    cur_digit = -1;
    if (!rst && n >= LAT) begin
      j  = (n - LAT) / SCAN_DIV;
      d  = j % DIGITS;
      s  = (SCAN_DIV - 1) + SCAN_DIV * (j - d);
      ch = hist_sw[s];
      td = hist_data[s];
      tp = hist_dp[s];
      e_pos  = ~(DIGITS'(1) << d);
      e_disp = {~tp[ch*DIGITS+d], hex_seg(td[(ch*DIGITS+d)*4 +: 4])};
      blank = 0;
`ifdef SEG_LZ_BLANK_EN
      if (d > 0) begin
        blank = 1;
        for (int k = d; k < DIGITS; k++)
          if (td[(ch*DIGITS+k)*4 +: 4] != 0 || tp[ch*DIGITS+k]) blank = 0;
      end
`endif
      if (blank) e_disp = 8'hFF;
      e_fs = ((n - LAT) % SCAN_DIV == 0) && (d == 0);
      cur_digit = d;
      cur_src = s;
    end
    check("led_pos", 32'(led_pos), 32'(e_pos));
    check("led_display", 32'(led_display), 32'(e_disp));
    check("frame_start", 32'(fs), 32'(e_fs));
    n = rst ? 0 : n + 1;
    @(negedge clk);
  endtask

  task automatic rand_all();
    data = {$urandom, $urandom, $urandom, $urandom};
    dp   = $urandom;
  endtask

  logic [7:0] pat_a [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
  int pd;

  initial begin
    rst = 1'b1;
    sw  = 3'd2;
    rand_all();
    data[2*16 +: 16] = 16'h12AF;
    dp[2*4 +: 4]     = 4'h0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;

    // fixed channel 2 pattern while other channels churn
    repeat (48) begin
      rand_all();
      data[2*16 +: 16] = 16'h12AF;
      dp[2*4 +: 4]     = 4'h0;
      step();
      if (cur_digit >= 0)
        check("pat_12AF", 32'(led_display), 32'(pat_a[cur_digit]));
    end

    // mid-frame channel switch
    repeat (6) step();
    sw = 3'd5;
    repeat (40) begin
      rand_all();
      step();
    end

    repeat (200) begin
      rand_all();
      if ($urandom_range(0, 7) == 0) sw = $urandom;
      step();
    end

    sw = 3'd1;
    pd = n;
    repeat (40) begin
      rand_all();
      data[1*16 +: 16] = 16'h0007;
      dp[1*4 +: 4]     = 4'h0;
      step();
      if (cur_digit >= 0 && cur_src >= pd) begin
`ifdef SEG_LZ_BLANK_EN
        check("lz_0007", 32'(led_display),
              cur_digit == 0 ? 32'hF8 : 32'hFF);
`else
        check("nolz_0007", 32'(led_display),
              cur_digit == 0 ? 32'hF8 : 32'hC0);
`endif
      end
    end

    // single-cycle reset mid-frame
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (60) begin
      rand_all();
      if ($urandom_range(0, 5) == 0) sw = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
